// File: rtl/mmult_pkg.sv
// Shared definitions for the 3x3 matrix multiplier, its result serializer and the UART wrapper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mmult_pkg;

    localparam int DATA_W     = 18;
    localparam int N          = 3;
    localparam int HEX_DIGITS = (DATA_W + 3) / 4;

    localparam int ELEM_IDX_W = $clog2(N * N);
    localparam int DIG_IDX_W  = $clog2(HEX_DIGITS);

    localparam logic [ELEM_IDX_W-1:0] LAST_ELEM = ELEM_IDX_W'(N * N - 1);
    localparam logic [DIG_IDX_W-1:0]  LAST_DIG  = DIG_IDX_W'(HEX_DIGITS - 1);

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        DIGIT,
        SEP,
        CR,
        LF,
        FIN
    } tx_state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Converts one 4-bit value to its uppercase ASCII hex character.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4-bit value in), ascii (8-bit character out).
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // '0'..'9' are 0x30..0x39; 'A'..'F' are 0x41..0x46, i.e. 0x37 + value.
    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = 8'h30 | {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/mmult_result_tx.sv
// Streams a latched 3x3 result matrix as ASCII hex text ("XXXXX XXXXX XXXXX\r\n" per row, 57 bytes).
// Latency: accept at edge t, first byte valid after t, bytes transfer t+1..t+57, done sampled at t+58.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; 1 byte/cycle when tx_ready stays high.
// Ports: clk, reset (sync, active-high), start/c_mat (request + matrix, element 0 in the
//        most significant slice), busy, tx_data/tx_valid/tx_ready (byte stream), done (1-cycle pulse).
module mmult_result_tx
    import mmult_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N*N*DATA_W-1:0]    c_mat,
    output logic                     busy,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     done
);

    tx_state_t               state;
    logic [N*N*DATA_W-1:0]   mat_q;
    logic [ELEM_IDX_W-1:0]   elem_idx;
    logic [DIG_IDX_W-1:0]    dig_idx;

    logic                    xfer;
    logic                    dig_last;
    logic                    col_last;
    logic                    row_last;

    logic [N*N*DATA_W-1:0]   src_mat;
    logic [ELEM_IDX_W-1:0]   nib_elem;
    logic [DIG_IDX_W-1:0]    nib_dig;
    logic [DATA_W-1:0]       elems [N*N];
    logic [HEX_DIGITS*4-1:0] elem_wide;
    logic [3:0]              digits [HEX_DIGITS];
    logic [3:0]              nib;
    logic [7:0]              dig_char;

    assign xfer     = tx_valid && tx_ready;
    assign dig_last = (dig_idx == LAST_DIG);
    assign row_last = (elem_idx == LAST_ELEM);
    assign col_last = ((int'(elem_idx) % N) == N - 1);

    // The next byte is prepared combinationally so it can be loaded on the same
    // edge that transfers the current one. On the accept edge the matrix register
    // is not yet loaded, so the first digit is taken straight from c_mat.
    always_comb begin
        src_mat  = (state == IDLE) ? c_mat : mat_q;
        nib_elem = elem_idx;
        nib_dig  = '0;
        case (state)
            IDLE:    nib_elem = '0;
            DIGIT:   nib_dig  = dig_last ? '0 : dig_idx + 1'b1;
            SEP:     nib_elem = elem_idx + 1'b1;
            LF:      nib_elem = row_last ? '0 : elem_idx + 1'b1;
            default: nib_elem = elem_idx;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N * N; k++) begin
            elems[k] = src_mat[(N*N-1-k)*DATA_W +: DATA_W];
        end
    end

    // Zero-extend to a whole number of hex digits; most significant digit first.
    assign elem_wide = (HEX_DIGITS*4)'(elems[nib_elem]);

    always_comb begin
        for (int d = 0; d < HEX_DIGITS; d++) begin
            digits[d] = elem_wide[(HEX_DIGITS-1-d)*4 +: 4];
        end
    end

    assign nib = digits[nib_dig];

    nibble_to_ascii u_n2a (
        .nibble (nib),
        .ascii  (dig_char)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mat_q    <= '0;
            elem_idx <= '0;
            dig_idx  <= '0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mat_q    <= c_mat;
                        elem_idx <= '0;
                        dig_idx  <= '0;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_data  <= dig_char;
                        state    <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (xfer) begin
                        if (!dig_last) begin
                            dig_idx <= dig_idx + 1'b1;
                            tx_data <= dig_char;
                        end else begin
                            dig_idx <= '0;
                            if (col_last) begin
                                tx_data <= ASCII_CR;
                                state   <= CR;
                            end else begin
                                tx_data <= ASCII_SP;
                                state   <= SEP;
                            end
                        end
                    end
                end
                SEP: begin
                    if (xfer) begin
                        elem_idx <= elem_idx + 1'b1;
                        tx_data  <= dig_char;
                        state    <= DIGIT;
                    end
                end
                CR: begin
                    if (xfer) begin
                        tx_data <= ASCII_LF;
                        state   <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        if (row_last) begin
                            elem_idx <= '0;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            elem_idx <= elem_idx + 1'b1;
                            tx_data  <= dig_char;
                            state    <= DIGIT;
                        end
                    end
                end
                FIN: begin
                    // start is deliberately not looked at here; a new request
                    // is only accepted from IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
